game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 60, meaning frame_tick pulses per countdown step.
REQ-002 SHALL have parameter DYING_FRAMES, default 45, meaning frame_tick pulses spent in DYING.
REQ-003 SHALL have parameter SCORE_MAX, default 9999, meaning the score saturation value (fits the 4-digit display).
REQ-004 SHALL have port clk  in  1  100 MHz system clock; the single clock.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start_btn  in  1  debounced start level.
REQ-007 SHALL have port jump_btn  in  1  debounced jump level.
REQ-008 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-009 SHALL have port collision  in  1  bird/pipe/ground overlap level from the game engine.
REQ-010 SHALL have port pipe_passed  in  1  one-cycle pulse when the bird clears a pipe.
REQ-011 SHALL have port state  out  3  current sequencer state code.
REQ-012 SHALL have port world_reset  out  1  holds the engine's bird and pipes at initial positions.
REQ-013 SHALL have port world_run  out  1  enables engine physics and scrolling.
REQ-014 SHALL have port jump_pulse  out  1  one-cycle jump request to the engine.
REQ-015 SHALL have port countdown  out  2  countdown digit for on-screen display.
REQ-016 SHALL have port score  out  14  current score, binary.
REQ-017 SHALL have port best_score  out  14  session best score, binary.

Function
REQ-018 SHALL implement states IDLE, READY, PLAY, DYING and OVER, with all outputs registered.
REQ-019 SHALL detect rising edges of start_btn and jump_btn using previous-value registers that reset to 1, so a button held through reset is not an edge.
REQ-020 IDLE SHALL drive world_reset=1 and world_run=0, and a start edge SHALL move to READY on the next cycle with score cleared to 0.
REQ-021 On entry to READY, countdown SHALL load 3 and SHALL decrement every FRAMES_PER_STEP frame_ticks; the tick that would make it 0 SHALL move to PLAY instead.
REQ-022 READY SHALL keep world_reset=1 and world_run=0.
REQ-023 countdown SHALL be 0 in every state except READY.
REQ-024 PLAY SHALL drive world_reset=0 and world_run=1.
REQ-025 In PLAY, a jump edge SHALL assert jump_pulse for exactly one cycle, one cycle after the edge.
REQ-026 jump edges SHALL be ignored in every state except PLAY.
REQ-027 In PLAY, each pipe_passed pulse SHALL increment score by 1, holding at SCORE_MAX.
REQ-028 In PLAY, collision SHALL be sampled only on frame_tick, and collision=1 at a frame_tick SHALL move to DYING.
REQ-029 If pipe_passed and a collision-sampling frame_tick occur in the same cycle, score SHALL increment and the state SHALL move to DYING.
REQ-030 DYING SHALL drive world_run=0 and world_reset=0 (frozen scene), and SHALL move to OVER after DYING_FRAMES frame_ticks.
REQ-031 OVER SHALL hold the scene frozen and the score visible, and a start edge SHALL move to READY with score cleared to 0.
REQ-032 Start edges in READY, PLAY and DYING SHALL be ignored.
REQ-033 state codes SHALL be IDLE=0, READY=1, PLAY=2, DYING=3, OVER=4, and codes 5-7 SHALL recover to IDLE on the next cycle.

Reset
REQ-034 While rst=1, the block SHALL asynchronously set state=IDLE, world_reset=1, world_run=0, jump_pulse=0, countdown=0, score=0, best_score=0, and clear all frame counters.
REQ-035 Reset asserted mid-PLAY SHALL abort immediately to IDLE, with no DYING/OVER pass and no best_score update.

Configuration
REQ-036 With HIGH_SCORE_EN defined, best_score SHALL update to score on the DYING->OVER transition when score > best_score, and SHALL persist until rst.
REQ-037 Without HIGH_SCORE_EN, best_score SHALL be tied to 0 and no best-score register SHALL exist.

Structure
REQ-038 Package flappy_pkg SHALL hold the state encoding, the score width (14), SCORE_MAX, and the countdown width.
REQ-039 Sub-module edge_pulse (one-bit rising-edge detector with reset-to-1 history) SHALL be instantiated once for start_btn and once for jump_btn.
REQ-040 The frame counter SHALL be shared between the READY and DYING states.

Verification
REQ-041 Bench SHALL cover: reset, then start edge, 180 frame_ticks -> countdown 3,2,1 at 60-tick intervals, PLAY after tick 180, world_run=1.
REQ-042 Bench SHALL cover: jump_btn held across rst deassert -> no jump_pulse; release then press in PLAY -> exactly one jump_pulse, one cycle after the edge.
REQ-043 Bench SHALL cover: 5 pipe_passed pulses, then collision at frame_tick -> score=5, DYING, OVER after 45 ticks, best_score=5 (HIGH_SCORE_EN).
REQ-044 Bench SHALL cover: pipe_passed coincident with a collision frame_tick -> score +1 and DYING on the same edge.
REQ-045 Bench SHALL cover: score preset near the limit with 3 further pipe_passed pulses -> score holds at 9999.
REQ-046 Bench SHALL cover: second game scoring 2 after best 5 -> best_score stays 5; rst mid-PLAY -> IDLE with best_score=0 on the next sampled edge.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game sequencer: state encoding, score
// and countdown widths, and the default score saturation value.
package flappy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_PLAY  = 3'd2,
      ST_DYING = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam int SCORE_W   = 14;
   localparam int SCORE_MAX = 9999;
   localparam int COUNT_W   = 2;

endpackage

// File: rtl/edge_pulse.sv
// One-bit rising-edge detector; history resets to 1 so a level already high
// when reset releases is not reported as an edge.
module edge_pulse (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b1;
      else     prev <= level;
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Top-level game flow FSM: IDLE -> READY countdown -> PLAY -> DYING -> OVER.
// Define HIGH_SCORE_EN to keep a session best score; otherwise best_score is 0.
module game_sequencer
   import flappy_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 60,
   parameter int DYING_FRAMES    = 45,
   parameter int SCORE_MAX       = flappy_pkg::SCORE_MAX
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_btn,
   input  logic               jump_btn,
   input  logic               frame_tick,
   input  logic               collision,
   input  logic               pipe_passed,
   output logic [2:0]         state,
   output logic               world_reset,
   output logic               world_run,
   output logic               jump_pulse,
   output logic [COUNT_W-1:0] countdown,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] best_score
);

   localparam int FRAME_CNT_MAX = (FRAMES_PER_STEP > DYING_FRAMES) ? FRAMES_PER_STEP : DYING_FRAMES;
   localparam int FRAME_CNT_W   = $clog2(FRAME_CNT_MAX + 1);

   state_t                 cur_state;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic [SCORE_W-1:0]     score_q;
   logic                   start_edge;
   logic                   jump_edge;

`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0]     best_q;
   assign best_score = best_q;
`else
   assign best_score = '0;
`endif

   edge_pulse u_start_edge (
      .clk   (clk),
      .rst   (rst),
      .level (start_btn),
      .pulse (start_edge)
   );

   edge_pulse u_jump_edge (
      .clk   (clk),
      .rst   (rst),
      .level (jump_btn),
      .pulse (jump_edge)
   );

   assign state = cur_state;
   assign score = score_q;

   // frame_cnt is shared: it paces countdown steps in READY and the death animation in DYING
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state   <= ST_IDLE;
         world_reset <= 1'b1;
         world_run   <= 1'b0;
         jump_pulse  <= 1'b0;
         countdown   <= '0;
         score_q     <= '0;
         frame_cnt   <= '0;
`ifdef HIGH_SCORE_EN
         best_q      <= '0;
`endif
      end else begin
         jump_pulse <= 1'b0;
         case (cur_state)
            ST_IDLE: begin
               world_reset <= 1'b1;
               world_run   <= 1'b0;
               countdown   <= '0;
               if (start_edge) begin
                  cur_state <= ST_READY;
                  countdown <= COUNT_W'(3);
                  score_q   <= '0;
                  frame_cnt <= '0;
               end
            end
            ST_READY: begin
               if (frame_tick) begin
                  if (frame_cnt == FRAME_CNT_W'(FRAMES_PER_STEP - 1)) begin
                     frame_cnt <= '0;
                     if (countdown == COUNT_W'(1)) begin
                        cur_state   <= ST_PLAY;
                        countdown   <= '0;
                        world_reset <= 1'b0;
                        world_run   <= 1'b1;
                     end else begin
                        countdown <= countdown - 1'b1;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               if (jump_edge)
                  jump_pulse <= 1'b1;
               if (pipe_passed && (score_q != SCORE_W'(SCORE_MAX)))
                  score_q <= score_q + 1'b1;
               if (frame_tick && collision) begin
                  cur_state <= ST_DYING;
                  world_run <= 1'b0;
                  frame_cnt <= '0;
               end
            end
            ST_DYING: begin
               if (frame_tick) begin
                  if (frame_cnt == FRAME_CNT_W'(DYING_FRAMES - 1)) begin
                     cur_state <= ST_OVER;
                     frame_cnt <= '0;
`ifdef HIGH_SCORE_EN
                     if (score_q > best_q)
                        best_q <= score_q;
`endif
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            ST_OVER: begin
               if (start_edge) begin
                  cur_state   <= ST_READY;
                  countdown   <= COUNT_W'(3);
                  score_q     <= '0;
                  frame_cnt   <= '0;
                  world_reset <= 1'b1;
               end
            end
            default: begin
               cur_state   <= ST_IDLE;
               world_reset <= 1'b1;
               world_run   <= 1'b0;
               countdown   <= '0;
               frame_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer; expected best score
// depends on whether HIGH_SCORE_EN is defined.
module tb_game_sequencer;

`ifdef HIGH_SCORE_EN
   localparam int EXP_BEST = 5;
`else
   localparam int EXP_BEST = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_btn;
   logic        jump_btn;
   logic        frame_tick;
   logic        collision;
   logic        pipe_passed;
   logic [2:0]  state;
   logic        world_reset;
   logic        world_run;
   logic        jump_pulse;
   logic [1:0]  countdown;
   logic [13:0] score;
   logic [13:0] best_score;

   int compareCount  = 0;
   int mismatchCount = 0;

   game_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start_btn   (start_btn),
      .jump_btn    (jump_btn),
      .frame_tick  (frame_tick),
      .collision   (collision),
      .pipe_passed (pipe_passed),
      .state       (state),
      .world_reset (world_reset),
      .world_run   (world_run),
      .jump_pulse  (jump_pulse),
      .countdown   (countdown),
      .score       (score),
      .best_score  (best_score)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Drive the pulse/level inputs for one clock, then settle just past the edge.
   task automatic applyStimulus(input logic ft, input logic col, input logic pp);
      frame_tick  = ft;
      collision   = col;
      pipe_passed = pp;
      @(posedge clk);
      #1;
      frame_tick  = 1'b0;
      collision   = 1'b0;
      pipe_passed = 1'b0;
   endtask

   task automatic frameTick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic pressStart();
      start_btn = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      start_btn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic runCountdown();
      for (int i = 1; i <= 180; i++) begin
         frameTick();
         if (i == 30) begin
            pressStart();
            checkOutput("ready_ignores_start_state", state, 1);
            checkOutput("ready_ignores_start_cd", countdown, 3);
         end
         if (i == 59) checkOutput("cd_before_60", countdown, 3);
         if (i == 60) checkOutput("cd_at_60", countdown, 2);
         if (i == 120) checkOutput("cd_at_120", countdown, 1);
         if (i == 179) begin
            checkOutput("ready_at_179", state, 1);
            checkOutput("world_run_at_179", world_run, 0);
         end
      end
      checkOutput("play_after_180", state, 2);
      checkOutput("play_world_run", world_run, 1);
      checkOutput("play_world_reset", world_reset, 0);
      checkOutput("play_countdown", countdown, 0);
   endtask

   task automatic dyingToOver(input int expScore);
      for (int i = 1; i <= 45; i++) begin
         frameTick();
         if (i == 44) checkOutput("dying_at_44", state, 3);
      end
      checkOutput("over_after_45", state, 4);
      checkOutput("over_score", score, expScore);
      checkOutput("over_best", best_score, EXP_BEST);
      checkOutput("over_world_run", world_run, 0);
      checkOutput("over_world_reset", world_reset, 0);
   endtask

   initial begin
      rst         = 1'b1;
      start_btn   = 1'b0;
      jump_btn    = 1'b1;
      frame_tick  = 1'b0;
      collision   = 1'b0;
      pipe_passed = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rst_state", state, 0);
      checkOutput("rst_world_reset", world_reset, 1);
      checkOutput("rst_world_run", world_run, 0);
      checkOutput("rst_jump_pulse", jump_pulse, 0);
      checkOutput("rst_countdown", countdown, 0);
      checkOutput("rst_score", score, 0);
      checkOutput("rst_best", best_score, 0);
      #4 rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_after_rst", state, 0);

      // Game 1: countdown, jump handling, five pipes, then a crash
      start_btn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("start_to_ready", state, 1);
      checkOutput("ready_countdown", countdown, 3);
      checkOutput("ready_world_reset", world_reset, 1);
      runCountdown();

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("held_jump_no_pulse", jump_pulse, 0);
      end
      jump_btn = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("jump_released", jump_pulse, 0);
      jump_btn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("jump_pulse_high", jump_pulse, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("jump_pulse_one_cycle", jump_pulse, 0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
      checkOutput("score_after_5", score, 5);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("collision_dying", state, 3);
      checkOutput("dying_score", score, 5);
      checkOutput("dying_world_run", world_run, 0);
      checkOutput("dying_world_reset", world_reset, 0);
      dyingToOver(5);

      // Game 2: pipe coincident with the crash frame
      pressStart();
      checkOutput("over_start_ready", state, 1);
      checkOutput("over_start_score_clear", score, 0);
      checkOutput("over_start_cd", countdown, 3);
      runCountdown();
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("coincident_score", score, 2);
      checkOutput("coincident_dying", state, 3);
      dyingToOver(2);

      // Game 3: saturate the score, then reset mid-play
      pressStart();
      checkOutput("game3_ready", state, 1);
      runCountdown();
      for (int i = 0; i < 9997; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
      checkOutput("score_9997", score, 9997);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("score_9998", score, 9998);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("score_9999", score, 9999);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("score_saturated", score, 9999);
      checkOutput("still_play", state, 2);

      #3 rst = 1'b1;
      #1;
      checkOutput("async_rst_state", state, 0);
      checkOutput("async_rst_score", score, 0);
      checkOutput("async_rst_world_run", world_run, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rst_mid_play_state", state, 0);
      checkOutput("rst_mid_play_best", best_score, 0);
      checkOutput("rst_mid_play_world_reset", world_reset, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
